// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM state encoding
//   DEF_*     : default geometry of the storage array
//   CNT_W     : width of the wait-state down-counter (WAIT_CYCLES 0..15)
//   idx_width : array index width for a given depth (never below 1)
package dmem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 256;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage for the data-memory responder.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low clear of every word and of the read register
//   wr_en  : write wdata to addr on the rising edge
//   rd_en  : load the read register from addr on the rising edge
//   addr   : word index shared by the read and write ports
//   wdata  : write data
//   rdata  : registered read data; holds its value while rd_en is low
// A read and write to the same word on the same edge returns the old word.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[addr] <= wdata;
            end
            if (rd_en) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the datapath load/store port.
// Accepts one request at a time, waits WAIT_CYCLES edges, performs the access
// on its own array and presents the result until the initiator takes it.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset (also clears the array)
//   req_valid  : request present            req_ready : request accepted this edge
//   req_write  : 1 = store, 0 = load        req_addr  : word address
//   req_wdata  : store data
//   rsp_valid  : response present           rsp_ready : initiator takes the response
//   rsp_rdata  : load data / echoed store data, 0 on out-of-range
//   rsp_err    : address was >= DEPTH       busy      : not in IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; captures req_* on acceptance
// WAIT    | counting down wait states; access happens on the edge after 0
// RESP    | response held on rsp_* until rsp_ready
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int                IDX_W     = idx_width(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rsp_word_q, rsp_word_d;
    logic               rsp_from_arr_q, rsp_from_arr_d;
    logic               rsp_err_q, rsp_err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic               addr_ok;
    logic               arr_we;
    logic               arr_re;
    logic [IDX_W-1:0]   arr_idx;
    logic [DATA_W-1:0]  arr_rdata;

    assign addr_ok = ({1'b0, addr_q} < DEPTH_LIM);
    assign arr_idx = addr_q[IDX_W-1:0];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rsp_word_d     = rsp_word_q;
        rsp_from_arr_d = rsp_from_arr_q;
        rsp_err_d      = rsp_err_q;
        arr_we         = 1'b0;
        arr_re         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d   = ST_RESP;
                    rsp_err_d = ~addr_ok;
                    if (!addr_ok) begin
                        rsp_from_arr_d = 1'b0;
                        rsp_word_d     = '0;
                    end else if (wr_q) begin
                        arr_we         = 1'b1;
                        rsp_from_arr_d = 1'b0;
                        rsp_word_d     = wdata_q;
                    end else begin
                        // Load data lands in the array's read register on this edge.
                        arr_re         = 1'b1;
                        rsp_from_arr_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered from the next state so they never
        // depend combinationally on req_* or rsp_ready.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rsp_word_q     <= '0;
            rsp_from_arr_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rsp_word_q     <= rsp_word_d;
            rsp_from_arr_q <= rsp_from_arr_d;
            rsp_err_q      <= rsp_err_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            busy_q         <= busy_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (arr_we),
        .rd_en  (arr_re),
        .addr   (arr_idx),
        .wdata  (wdata_q),
        .rdata  (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_from_arr_q ? arr_rdata : rsp_word_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
